bitty_uart_tx: RTL and testbench
================================

# bitty_uart_tx

Memory-mapped UART transmitter (8N1) attached to the core's data-memory port, alongside the data RAM. It sits directly downstream of the core's `ram_*` outputs: it decodes `ram_addr_o`, `ram_ce_o`, `ram_we_o`, `ram_sel_o` and `ram_data_o`, and returns read data on the core's `ram_data_i` path through the SoC read mux. Written bytes are queued in a small FIFO and serialized LSB-first on `tx_o` at a programmable baud rate.

## Interface
- `BASE_ADDR`, default 32'h1000_0000. Register window base; the block is selected when `addr_i[31:4] == BASE_ADDR[31:4]`.
- `FIFO_DEPTH`, default 8. TX FIFO entries; must be a power of 2, range 2–16.
- `DEFAULT_DIV`, default 16'd433. Reset value of BAUDDIV (50 MHz / 115200, minus 1).
- `clk` input, 1 bit. Single clock; all state updates on the rising edge.
- `rst` input, 1 bit. Asynchronous, active-low reset.
- `ce_i` input, 1 bit. Bus access enable (`ram_ce_o`).
- `we_i` input, 1 bit. 1 = write, 0 = read.
- `addr_i` input, 32 bits. Byte address.
- `sel_i` input, 4 bits. Byte lane enables; bit0 = `data_i[7:0]`.
- `data_i` input, 32 bits. Write data.
- `data_o` output, 32 bits. Read data; combinational.
- `tx_o` output, 1 bit. Serial line; idle high.

## Operation
- Select: `hit = ce_i & (addr_i[31:4] == BASE_ADDR[31:4])`. The register offset is `addr_i[3:2]`.
- Offset 0x0, TXDATA (write-only):
  - Write with `sel_i[0]=1` pushes `data_i[7:0]`.
  - If `sel_i[0]=0`, the write is ignored.
  - Reads return 0.
- Offset 0x4, STATUS:
  - Read fields: bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bits[7:3] count (5 bits), bit8 overflow (sticky), other bits 0.
  - A write with `sel_i[1]=1` and `data_i[8]=1` clears overflow.
- Offset 0x8, BAUDDIV:
  - Bits[15:0] are read/write, byte lanes per `sel_i[1:0]`; bits[31:16] read 0.
  - Each serial bit lasts BAUDDIV+1 cycles.
- Offset 0xC: reserved. Reads return 0; writes are ignored.
- `data_o` is 0 when `hit=0` or `we_i=1`. Reads have no side effects.
- FIFO:
  - Circular buffer with read/write pointers and a count of width log2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
  - A push while full is dropped and sets overflow.
  - Push and pop in the same cycle: both happen; count is unchanged. Pop happens only when count>0, so a push into an empty FIFO is never popped in the same cycle.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx_o=1`. If count>0, pop at the edge into an 8-bit shift register, load the baud counter with BAUDDIV, and go to START.
  - START: `tx_o=0`. When the baud counter reaches 0, reload it, set bit index to 0, and go to DATA.
  - DATA: `tx_o=shift[0]`. On each baud tick, shift right and increment the bit index. After the tick for bit 7, go to STOP.
  - STOP: `tx_o=1`. On the baud tick:
    - if count>0, pop and go to START (back-to-back frames with no idle gap);
    - else go to IDLE.
- Baud counter: counts down from BAUDDIV to 0. A tick occurs in the cycle the counter equals 0. On reload it samples the current BAUDDIV, so a mid-frame BAUDDIV write takes effect at the next bit boundary.
- BAUDDIV=0 is legal: each bit lasts 1 cycle.

## Timing
- Reset (`rst=0`, asynchronous): FSM IDLE, `tx_o=1`, FIFO empty, count 0, overflow 0, BAUDDIV=DEFAULT_DIV, shift register 0, baud counter 0. `data_o` stays combinational (0 when not selected).
- Reset asserted mid-frame: `tx_o` goes high immediately and queued bytes are discarded.
- Write latency: a TXDATA write sampled at edge k is counted in STATUS after edge k. If the FSM is IDLE, it pops at edge k+1, and `tx_o` falls after edge k+1.
- Frame length: 10×(BAUDDIV+1) cycles. With back-to-back frames, the next start bit begins on the cycle after the last stop-bit cycle.
- busy clears on the edge ending the last stop bit when the FIFO is empty.
- Read data is valid in the same cycle as the address, matching the core's single-cycle memory stage. No wait states.

## Test plan
- Reset with `rst=0` mid-traffic, then release: `tx_o=1`, STATUS reads 32'h0000_0004, BAUDDIV reads 433.
- Write BAUDDIV=3, then TXDATA=8'hA5:
  - `tx_o` is low for 4 cycles (start bit);
  - data bits are 1,0,1,0,0,1,0,1, each 4 cycles;
  - stop bit is high for 4 cycles;
  - busy clears 40 cycles after the pop.
- BAUDDIV=0, write 3 bytes back-to-back (8'h01, 8'h02, 8'h03): three contiguous 10-cycle frames with no idle gap between them; STATUS ends at 32'h0000_0004.
- BAUDDIV=7:
  - Write 10 bytes while the first frame is in progress.
  - Expected: the first byte is popped, 8 bytes are queued (full=1, count=8), and the 10th byte is dropped with overflow=1.
  - Then write STATUS with bit8=1: overflow clears.
  - All 9 accepted bytes transmit in order.
- Mid-frame BAUDDIV change from 3 to 1 during data bit 2: bit 2 keeps 4 cycles; all following bits last 2 cycles.
- Access-decode checks:
  - TXDATA write with `sel_i=4'b0010`: no push.
  - Read at an address outside the window, or with `ce_i=0`: `data_o=0`.
  - Write to offset 0xC: no state change.

Source files
------------

// File: rtl/bitty_uart_tx.sv
// bitty_uart_tx: memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Registers: 0x0 TXDATA (wo), 0x4 STATUS, 0x8 BAUDDIV, 0xC reserved.
module bitty_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        tx_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             state, state_next;
    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wptr, rptr;
    logic [CNT_W-1:0]   count;
    logic               overflow;
    logic [15:0]        div;
    logic [7:0]         shift, shift_next;
    logic [15:0]        baud_cnt, baud_next;
    logic [2:0]         bit_idx, bit_idx_next;
    logic               tx_next;
    logic               pop;

    logic               hit, wr, rd;
    logic [1:0]         off;
    logic               push_req, push, full, empty;
    logic               ovf_clr;
    logic               unused_bits;

    // Bus decode for the 16-byte register window
    assign hit      = ce_i & (addr_i[31:4] == BASE_ADDR[31:4]);
    assign wr       = hit & we_i;
    assign rd       = hit & ~we_i;
    assign off      = addr_i[3:2];
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign push_req = wr & (off == 2'd0) & sel_i[0];
    assign push     = push_req & ~full;
    assign ovf_clr  = wr & (off == 2'd1) & sel_i[1] & data_i[8];
    assign unused_bits = ^{addr_i[1:0], sel_i[3:2], data_i[31:16]};

    // Combinational read mux; reads have no side effects
    always_comb begin
        data_o = '0;
        if (rd) begin
            case (off)
                2'd1:    data_o = {23'd0, overflow, 5'(count), empty, full, (state != IDLE)};
                2'd2:    data_o = {16'd0, div};
                default: data_o = '0;
            endcase
        end
    end

    // BAUDDIV register with byte-lane writes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div <= DEFAULT_DIV;
        end else if (wr && off == 2'd2) begin
            if (sel_i[0]) div[7:0]  <= data_i[7:0];
            if (sel_i[1]) div[15:8] <= data_i[15:8];
        end
    end

    // FIFO storage; contents need no reset since pointers/count are cleared
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= data_i[7:0];
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wptr <= wptr + PTR_W'(1);
            if (pop)  rptr <= rptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (push_req && full) overflow <= 1'b1;
            else if (ovf_clr)     overflow <= 1'b0;
        end
    end

    // FSM state and serializer datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            shift    <= '0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_o     <= 1'b1;
        end else begin
            state    <= state_next;
            shift    <= shift_next;
            baud_cnt <= baud_next;
            bit_idx  <= bit_idx_next;
            tx_o     <= tx_next;
        end
    end

    // Next-state logic; tx_o is registered from the next state's line level
    always_comb begin
        state_next   = state;
        shift_next   = shift;
        baud_next    = baud_cnt;
        bit_idx_next = bit_idx;
        pop          = 1'b0;
        tx_next      = 1'b1;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = mem[rptr];
                    baud_next  = div;
                    state_next = START;
                end
            end
            START: begin
                if (baud_cnt == '0) begin
                    baud_next    = div;
                    bit_idx_next = '0;
                    state_next   = DATA;
                end else begin
                    baud_next = baud_cnt - 16'd1;
                end
            end
            DATA: begin
                if (baud_cnt == '0) begin
                    baud_next    = div;
                    shift_next   = {1'b0, shift[7:1]};
                    bit_idx_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_next = STOP;
                end else begin
                    baud_next = baud_cnt - 16'd1;
                end
            end
            STOP: begin
                if (baud_cnt == '0) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        shift_next = mem[rptr];
                        baud_next  = div;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_cnt - 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_bitty_uart_tx.sv
// Self-checking bench for bitty_uart_tx: bus driver + serial-line scoreboard.
module tb_bitty_uart_tx;

    localparam logic [31:0] A_TX  = 32'h1000_0000;
    localparam logic [31:0] A_ST  = 32'h1000_0004;
    localparam logic [31:0] A_DIV = 32'h1000_0008;
    localparam logic [31:0] A_RSV = 32'h1000_000C;

    typedef struct packed {
        logic [7:0]      data;
        logic [9:0][7:0] dur;   // cycles per line bit: start, d0..d7, stop
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce_i = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [3:0]  sel_i = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic        tx_o;

    int   checks = 0;
    int   failures = 0;
    exp_t sbq[$];
    bit   mon_en = 0;
    bit   in_frame = 0;
    int   cur_div = 433;

    bitty_uart_tx dut (
        .clk    (clk),
        .rst    (rst),
        .ce_i   (ce_i),
        .we_i   (we_i),
        .addr_i (addr_i),
        .sel_i  (sel_i),
        .data_i (data_i),
        .data_o (data_o),
        .tx_o   (tx_o)
    );

    always #5 clk = ~clk;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] status_word(input bit busy, input bit full, input bit empty,
                                                input int cnt, input bit ovf);
        return {23'd0, ovf, 5'(cnt), empty, full, busy};
    endfunction

    function automatic exp_t mk(input logic [7:0] b, input int div);
        exp_t e;
        e.data = b;
        for (int i = 0; i < 10; i++) e.dur[i] = 8'(div + 1);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        @(negedge clk);
        ce_i = 1'b1; we_i = 1'b1; addr_i = a; sel_i = s; data_i = d;
        @(posedge clk);
        #1;
        ce_i = 1'b0; we_i = 1'b0; addr_i = '0; sel_i = '0; data_i = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        ce_i = 1'b1; we_i = 1'b0; addr_i = a; sel_i = 4'hF;
        #1;
        d = data_o;
        ce_i = 1'b0; addr_i = '0; sel_i = '0;
    endtask

    task automatic set_div(input int d);
        wr(A_DIV, 4'b0011, 32'(d));
        cur_div = d;
    endtask

    task automatic send(input logic [7:0] b);
        wr(A_TX, 4'b0001, {24'd0, b});
        sbq.push_back(mk(b, cur_div));
    endtask

    // Poll until the transmitter is idle and every expected frame was seen
    task automatic wait_idle(input string nm);
        logic [31:0] s;
        bit done = 0;
        int n = 0;
        s = '0;
        while (!done && n < 3000) begin
            rd(A_ST, s);
            if (s[2:0] == 3'b100 && sbq.size() == 0 && !in_frame) done = 1;
            n++;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s_timeout got_status=%h pending_frames=%0d exp_pending=0", nm, s, sbq.size());
            sbq.delete();
        end
        chk({nm, "_status"}, s, status_word(0, 0, 1, 0, 0));
    endtask

    // Serial-line monitor: every start bit pops one expected frame
    exp_t       me;
    bit         ok_f;
    bit         first;
    logic [7:0] obs;
    logic       lvl;
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && rst && tx_o === 1'b0) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame got=start_bit exp=idle_line");
                    for (int w = 0; w < 200 && tx_o === 1'b0; w++) @(negedge clk);
                end else begin
                    in_frame = 1;
                    me = sbq.pop_front();
                    ok_f = 1;
                    first = 1;
                    obs = '0;
                    for (int b = 0; b < 10; b++) begin
                        if (b == 0)      lvl = 1'b0;
                        else if (b == 9) lvl = 1'b1;
                        else             lvl = me.data[b-1];
                        for (int c = 0; c < int'(me.dur[b]); c++) begin
                            if (!first) @(negedge clk);
                            first = 0;
                            if (tx_o !== lvl) ok_f = 0;
                            if (c == 0 && b >= 1 && b <= 8) obs[b-1] = tx_o;
                        end
                    end
                    checks++;
                    if (!ok_f) begin
                        failures++;
                        $display("FAIL frame got_byte=%h exp_byte=%h (line level or bit timing wrong)",
                                 obs, me.data);
                    end
                    in_frame = 0;
                end
            end
        end
    end

    // Stimulus sequence
    initial begin
        logic [31:0] r;
        logic [7:0]  b;
        exp_t        e;
        bit          stayed_high;
        int          nb;

        // Power-on reset
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        chk("por_tx", 32'(tx_o), 32'd1);
        rd(A_ST, r);  chk("por_status", r, 32'h0000_0004);
        rd(A_DIV, r); chk("por_div", r, 32'd433);

        // Reset asserted mid-frame drops the line high and discards the FIFO
        set_div(3);
        wr(A_TX, 4'b0001, 32'h0000_0000);
        wr(A_TX, 4'b0001, 32'h0000_0055);
        repeat (8) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1 chk("rst_async_tx", 32'(tx_o), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        cur_div = 433;
        stayed_high = 1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tx_o !== 1'b1) stayed_high = 0;
        end
        chk("rst_line_idle", 32'(stayed_high), 32'd1);
        rd(A_ST, r);  chk("rst_status", r, 32'h0000_0004);
        rd(A_DIV, r); chk("rst_div", r, 32'd433);
        mon_en = 1;

        // BAUDDIV byte lanes and read-zero upper half
        wr(A_DIV, 4'b0001, 32'h0000_00CD);
        rd(A_DIV, r); chk("div_lane0", r, 32'h0000_01CD);
        wr(A_DIV, 4'b0010, 32'h0000_AB00);
        rd(A_DIV, r); chk("div_lane1", r, 32'h0000_ABCD);
        wr(A_DIV, 4'b1111, 32'hFFFF_0003);
        cur_div = 3;
        rd(A_DIV, r); chk("div_upper_zero", r, 32'h0000_0003);

        // 0xA5 at BAUDDIV=3; busy clears 40 cycles after the pop
        send(8'hA5);
        repeat (40) @(posedge clk);
        rd(A_ST, r); chk("a5_busy_before_end", r, status_word(1, 0, 1, 0, 0));
        rd(A_ST, r); chk("a5_busy_cleared", r, status_word(0, 0, 1, 0, 0));
        wait_idle("a5");

        // BAUDDIV=0, three back-to-back frames
        set_div(0);
        send(8'h01);
        send(8'h02);
        send(8'h03);
        wait_idle("div0_b2b");

        // Overflow: 10 writes during the first frame, 10th dropped
        set_div(7);
        for (int i = 0; i < 9; i++) send(8'($urandom));
        wr(A_TX, 4'b0001, 32'($urandom));
        rd(A_ST, r); chk("ovf_status_full", r, status_word(1, 1, 0, 8, 1));
        wr(A_ST, 4'b0010, 32'h0000_0100);
        rd(A_ST, r); chk("ovf_cleared", r, status_word(1, 1, 0, 8, 0));
        wait_idle("ovf_drain");

        // Mid-frame BAUDDIV change 3 -> 1 during data bit 2
        set_div(3);
        b = 8'($urandom);
        wr(A_TX, 4'b0001, {24'd0, b});
        e.data = b;
        for (int i = 0; i < 10; i++) e.dur[i] = (i <= 3) ? 8'd4 : 8'd2;
        sbq.push_back(e);
        repeat (13) @(posedge clk);
        set_div(1);
        wait_idle("div_change");

        // Randomized bursts at random baud divisors
        for (int t = 0; t < 6; t++) begin
            set_div(int'($urandom_range(0, 4)));
            nb = int'($urandom_range(1, 6));
            for (int i = 0; i < nb; i++) send(8'($urandom));
            wait_idle("random_burst");
        end

        // Access decode
        wr(A_TX, 4'b0010, 32'h0000_00FF);
        repeat (5) @(posedge clk);
        rd(A_ST, r); chk("tx_sel1_no_push", r, 32'h0000_0004);
        rd(32'h1000_0014, r); chk("rd_outside_window", r, 32'h0);
        rd(32'h2000_0004, r); chk("rd_other_region", r, 32'h0);
        @(negedge clk);
        ce_i = 1'b0; we_i = 1'b0; addr_i = A_ST; sel_i = 4'hF;
        #1 chk("rd_ce_low", data_o, 32'h0);
        ce_i = 1'b1; we_i = 1'b1; sel_i = 4'h0;
        #1 chk("rd_we_high", data_o, 32'h0);
        ce_i = 1'b0; we_i = 1'b0; addr_i = '0;
        wr(A_RSV, 4'hF, 32'hFFFF_FFFF);
        repeat (5) @(posedge clk);
        rd(A_ST, r);  chk("rsv_wr_status", r, 32'h0000_0004);
        rd(A_DIV, r); chk("rsv_wr_div", r, 32'(cur_div));
        rd(A_RSV, r); chk("rsv_rd_zero", r, 32'h0);
        rd(A_TX, r);  chk("txdata_rd_zero", r, 32'h0);
        chk("idle_line_high", 32'(tx_o), 32'd1);

        wait_idle("final");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
